alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter W, default 8, byte width of the 8-bit ALU datapath sequenced by this block.
REQ-002 Parameter NBYTES, default 4, maximum operand length in bytes; operand width is W*NBYTES.
REQ-003 Port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  block can accept a request.
REQ-007 Port req_op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; 5-7 illegal.
REQ-008 Port req_len  input  2  operand length minus one, in bytes (0 = 1 byte, 3 = 4 bytes).
REQ-009 Port req_a, req_b  input  W*NBYTES  operands, little-endian bytes.
REQ-010 Port rsp_valid  output  1  response present.
REQ-011 Port rsp_ready  input  1  consumer accepts response.
REQ-012 Port rsp_result  output  W*NBYTES  result; bytes above req_len are zero.
REQ-013 Port rsp_carry, rsp_zero, rsp_neg, rsp_err  output  1 each  final carry, whole-result zero, sign bit, illegal-op flag.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, DONE; req_ready = 1 only in IDLE; rsp_valid = 1 only in DONE.
REQ-015 In IDLE with req_valid = 1 the block SHALL capture op, len, A, B, clear byte index to 0, clear result, and go to EXEC (legal op) or DONE with rsp_err = 1, result 0, flags 0 (illegal op).
REQ-016 In EXEC the block SHALL process exactly one byte per cycle, LSB first, driving the ALU with byte idx of A as InputA and byte idx of B (inverted for SUB) as InputB.
REQ-017 ALU opcode mapping SHALL be: ADD and SUB -> add-with-carry (4'b0000), AND -> 4'b0010, OR -> 4'b0011, XOR -> 4'b0100.
REQ-018 Carry chain: SC_in for byte 0 SHALL be 0 for ADD and 1 for SUB; for byte i>0 SHALL be the registered SC_out of byte i-1.
REQ-019 The ALU output byte SHALL be written into result byte idx each EXEC cycle; EXEC SHALL exit to DONE after the cycle with idx == len.
REQ-020 Latency: rsp_valid SHALL rise len+2 rising edges after the accepting edge (len+1 EXEC cycles); illegal op: 1 edge.
REQ-021 rsp_carry SHALL be SC_out of the final byte for ADD/SUB (SUB: 1 = no borrow, A >= B unsigned) and 0 for logical ops.
REQ-022 rsp_zero SHALL be 1 iff all processed result bytes are zero; rsp_neg SHALL equal result bit W*(len+1)-1.
REQ-023 In DONE, rsp_result and all flags SHALL hold stable until rsp_ready = 1; on that edge the FSM SHALL return to IDLE.
REQ-024 Requests arriving outside IDLE SHALL be ignored; no request is accepted in the same cycle a response is consumed.
REQ-025 Captured operands SHALL not be affected by req_a/req_b changes after acceptance.

Reset
REQ-026 Reset SHALL force IDLE, req_ready = 1, rsp_valid = 0, rsp_result = 0, all flags 0, byte index 0, carry register 0.
REQ-027 Reset asserted in EXEC or DONE SHALL abandon the operation; no response for it is ever produced.

Structure
REQ-028 A shared package alu_seq_pkg SHALL hold the req_op enum, the ALU opcode constants, and the FSM state enum.
REQ-029 The block SHALL instantiate exactly one ALU sub-module (ALU, W=8) as its only datapath; all sequencing, carry and result registers live in alu_seq_ctrl.
REQ-030 Unused ALU flag outputs (Parity, Odd) SHALL be left unconnected.

Verification
REQ-031 ADD len=3, A=0xFFFFFFFF, B=0x00000001 -> result 0x00000000, carry 1, zero 1, neg 0, rsp_valid 5 edges after accept.
REQ-032 SUB len=1, A=0x00000001, B=0x00000002 -> result 0x0000FFFF, carry 0, neg 1; then SUB len=1, A=0x0100, B=0x0001 -> 0x000000FF, carry 1, neg 0.
REQ-033 AND len=0, A=0xFFFFFF0F, B=0x000000F0 -> result 0x00000000, zero 1, carry 0, upper bytes zero.
REQ-034 rsp_ready held 0 for 5 cycles in DONE with req_valid = 1 -> outputs stable, req_ready 0, second request accepted only after response consumed.
REQ-035 Reset pulsed during EXEC of a len=3 ADD -> next cycle IDLE, req_ready 1, rsp_valid 0; req_op=7 -> rsp_err 1, result 0, 1 edge after accept.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the byte-serial ALU sequencer:
//   - req_op_e   : request operation codes (values 5-7 are illegal)
//   - ALU_*      : opcodes understood by the 8-bit ALU sub-module
//   - state_e    : sequencer FSM states
//   - isLegalOp  : helper that tells legal request opcodes from illegal ones
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } req_op_e;

  localparam logic [3:0] ALU_ADDC = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Anything above XOR has no meaning to the datapath
  function automatic logic isLegalOp(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// ---------------------------------------------------------------------------
// ALU
// Purely combinational W-bit ALU used one byte at a time by the sequencer.
// Ports:
//   InputA, InputB : operand bytes
//   OpCode         : 0000 add-with-carry, 0010 AND, 0011 OR, 0100 XOR
//   SC_in          : carry into the adder
//   Result         : W-bit result
//   SC_out         : adder carry out (0 for logical operations)
//   Parity, Odd    : even-parity of Result, and Result LSB
// ---------------------------------------------------------------------------
module ALU
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  input  logic [3:0]   OpCode,
  input  logic         SC_in,
  output logic [W-1:0] Result,
  output logic         SC_out,
  output logic         Parity,
  output logic         Odd
);

  logic [W:0] sum;

  // One extra bit on the adder captures the carry out; unknown opcodes
  // produce zero so an unexpected code never leaks stale data
  always_comb begin
    sum    = {1'b0, InputA} + {1'b0, InputB} + (W+1)'(SC_in);
    Result = '0;
    SC_out = 1'b0;
    case (OpCode)
      ALU_ADDC: begin
        Result = sum[W-1:0];
        SC_out = sum[W];
      end
      ALU_AND: Result = InputA & InputB;
      ALU_OR:  Result = InputA | InputB;
      ALU_XOR: Result = InputA ^ InputB;
      default: Result = '0;
    endcase
  end

  assign Parity = ^Result;
  assign Odd    = Result[0];

endmodule

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Runs multi-byte ADD/SUB/AND/OR/XOR through a single 8-bit ALU, one byte per
// cycle, least significant byte first, rippling the carry through a register.
// Ports:
//   Clk, Reset           : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only while idle)
//   req_op, req_len      : operation, operand length minus one in bytes
//   req_a, req_b         : little-endian operands
//   rsp_valid/rsp_ready  : response handshake (valid only while done)
//   rsp_result           : result, bytes above the length are zero
//   rsp_carry/zero/neg/err : final carry, zero, sign and illegal-op flags
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int W      = 8,
  parameter int NBYTES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [1:0]        req_len,
  input  logic [W*NBYTES-1:0] req_a,
  input  logic [W*NBYTES-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W*NBYTES-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic              rsp_err
);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          len_q, len_d;
  logic [1:0]          idx_q, idx_d;
  logic [W*NBYTES-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic                carry_q, carry_d;
  logic                flagCarry_q, flagCarry_d, flagZero_q, flagZero_d;
  logic                flagNeg_q, flagNeg_d, flagErr_q, flagErr_d;

  logic [W-1:0]        aluA, aluB, aluY;
  logic [3:0]          aluOp;
  logic                aluCin, aluCout, isArith;

  // Feed the ALU with the current byte; SUB is A + ~B + 1, so B is inverted
  // and the first byte gets a carry-in of one instead of zero
  always_comb begin
    isArith = (op_q == OP_ADD) || (op_q == OP_SUB);
    aluA    = a_q[int'(idx_q)*W +: W];
    aluB    = b_q[int'(idx_q)*W +: W];
    if (op_q == OP_SUB) aluB = ~aluB;
    aluCin  = (idx_q == 2'd0) ? (op_q == OP_SUB) : carry_q;
    case (op_q)
      OP_AND:  aluOp = ALU_AND;
      OP_OR:   aluOp = ALU_OR;
      OP_XOR:  aluOp = ALU_XOR;
      default: aluOp = ALU_ADDC;
    endcase
  end

  ALU #(.W(8)) uAlu (
    .InputA (aluA),
    .InputB (aluB),
    .OpCode (aluOp),
    .SC_in  (aluCin),
    .Result (aluY),
    .SC_out (aluCout),
    .Parity (),
    .Odd    ()
  );

  // Next-state logic: capture in IDLE, one byte per EXEC cycle, then hold
  // the response in DONE until the consumer takes it. Zero is judged on the
  // updated result, which is safe because unprocessed bytes were cleared.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    flagCarry_d = flagCarry_q;
    flagZero_d  = flagZero_q;
    flagNeg_d   = flagNeg_q;
    flagErr_d   = flagErr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          len_d       = req_len;
          a_d         = req_a;
          b_d         = req_b;
          idx_d       = 2'd0;
          result_d    = '0;
          carry_d     = 1'b0;
          flagCarry_d = 1'b0;
          flagZero_d  = 1'b0;
          flagNeg_d   = 1'b0;
          flagErr_d   = !isLegalOp(req_op);
          state_d     = isLegalOp(req_op) ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: begin
        result_d[int'(idx_q)*W +: W] = aluY;
        carry_d = aluCout;
        idx_d   = idx_q + 2'd1;
        if (idx_q == len_q) begin
          idx_d       = 2'd0;
          flagCarry_d = isArith & aluCout;
          flagZero_d  = (result_d == '0);
          flagNeg_d   = aluY[W-1];
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; reset drops any operation in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      len_q       <= 2'd0;
      idx_q       <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      flagCarry_q <= 1'b0;
      flagZero_q  <= 1'b0;
      flagNeg_q   <= 1'b0;
      flagErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      flagCarry_q <= flagCarry_d;
      flagZero_q  <= flagZero_d;
      flagNeg_q   <= flagNeg_d;
      flagErr_q   <= flagErr_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = result_q;
  assign rsp_carry  = flagCarry_q;
  assign rsp_zero   = flagZero_q;
  assign rsp_neg    = flagNeg_q;
  assign rsp_err    = flagErr_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed bench for the byte-serial ALU sequencer with hand-computed results.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [1:0]  req_len = 2'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_neg, rsp_err;

  int checkCount = 0;
  int passCount  = 0;
  int edges;

  alu_seq_ctrl #(.W(8), .NBYTES(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_len    (req_len),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .rsp_err    (rsp_err)
  );

  // Free-running 10 time-unit clock
  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Present one request, count edges from the accepting edge (edge 1) until
  // rsp_valid shows, and scramble the operand inputs right after acceptance
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] len,
                               input logic [31:0] a, input logic [31:0] b,
                               output int nEdges);
    @(negedge Clk);
    req_valid = 1'b1;
    req_op    = op;
    req_len   = len;
    req_a     = a;
    req_b     = b;
    @(posedge Clk);
    nEdges = 1;
    #1;
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'hA5A5_A5A5;
    while (!rsp_valid && nEdges < 20) begin
      @(posedge Clk);
      nEdges++;
      #1;
    end
  endtask

  // Compare a full response against hand-computed values
  task automatic checkResponse(input string tag, input int nEdges, input int expEdges,
                               input logic [31:0] expResult, input logic expCarry,
                               input logic expZero, input logic expNeg, input logic expErr);
    checkOutput({tag, ".latency"}, 32'(nEdges), 32'(expEdges));
    checkOutput({tag, ".valid"},   32'(rsp_valid), 32'd1);
    checkOutput({tag, ".result"},  rsp_result, expResult);
    checkOutput({tag, ".carry"},   32'(rsp_carry), 32'(expCarry));
    checkOutput({tag, ".zero"},    32'(rsp_zero), 32'(expZero));
    checkOutput({tag, ".neg"},     32'(rsp_neg), 32'(expNeg));
    checkOutput({tag, ".err"},     32'(rsp_err), 32'(expErr));
  endtask

  // Accept the pending response with a one-cycle rsp_ready pulse
  task automatic consume();
    @(negedge Clk);
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    int seen;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset.req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.result",    rsp_result, 32'd0);
    checkOutput("reset.flags", {28'd0, rsp_carry, rsp_zero, rsp_neg, rsp_err}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Full-length add wrapping to zero with carry out
    applyStimulus(3'd0, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001, edges);
    checkResponse("add4", edges, 5, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    consume();

    // Two-byte subtract with borrow, then without
    applyStimulus(3'd1, 2'd1, 32'h0000_0001, 32'h0000_0002, edges);
    checkResponse("sub2a", edges, 3, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    consume();
    applyStimulus(3'd1, 2'd1, 32'h0000_0100, 32'h0000_0001, edges);
    checkResponse("sub2b", edges, 3, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0);
    consume();

    // Single-byte AND: upper operand bytes must not reach the result
    applyStimulus(3'd2, 2'd0, 32'hFFFF_FF0F, 32'h0000_00F0, edges);
    checkResponse("and1", edges, 2, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    consume();

    // Three-byte XOR, then hold it in DONE while a new request waits
    applyStimulus(3'd4, 2'd2, 32'h0012_3456, 32'h00FF_00FF, edges);
    checkResponse("xor3", edges, 4, 32'h00ED_34A9, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge Clk);
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_len   = 2'd1;
    req_a     = 32'h0000_1200;
    req_b     = 32'h0000_0034;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      checkOutput("hold.result",    rsp_result, 32'h00ED_34A9);
      checkOutput("hold.neg",       32'(rsp_neg), 32'd1);
      checkOutput("hold.req_ready", 32'(req_ready), 32'd0);
      checkOutput("hold.rsp_valid", 32'(rsp_valid), 32'd1);
    end
    // Consume edge must not also accept the waiting request
    consume();
    checkOutput("handoff.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("handoff.req_ready", 32'(req_ready), 32'd1);
    @(posedge Clk);
    edges = 1;
    #1;
    req_valid = 1'b0;
    checkOutput("handoff.accepted", 32'(req_ready), 32'd0);
    while (!rsp_valid && edges < 20) begin
      @(posedge Clk);
      edges++;
      #1;
    end
    checkResponse("or2", edges, 3, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();

    // Reset in the middle of a long add abandons it
    @(negedge Clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_len   = 2'd3;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'h0000_0001;
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    checkOutput("midreset.req_ready", 32'(req_ready), 32'd1);
    checkOutput("midreset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset.result",    rsp_result, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    checkOutput("midreset.abandoned", 32'(seen), 32'd0);

    // Illegal opcode answers after one edge with only the error flag set
    applyStimulus(3'd7, 2'd3, 32'h1234_5678, 32'h1111_1111, edges);
    checkResponse("illegal", edges, 1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    consume();
    checkOutput("illegal.back_idle", 32'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
